// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache controller between fetch and the memory arbiter.
// Ports:
//   clk, reset (async, active-low)
//   fetch side : fetch_reqcyc/fetch_addr in, fetch_ready/fetch_respcyc/fetch_data out
//   flush      : level-sampled whole-cache invalidate
//   mem side   : mem_reqcyc/mem_req/mem_reqtag out with mem_reqack in,
//                mem_respcyc/mem_resp/mem_resptag in (one 64-byte line per request)
module icache_ctrl #(
    parameter int          NUM_SETS  = 64,
    parameter int          LINE_BITS = 512,
    parameter int          TAG_WIDTH = 13,
    parameter logic [11:0] MEM_TAG   = 12'h001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_reqcyc,
    input  logic [63:0]          fetch_addr,
    output logic                 fetch_ready,
    output logic                 fetch_respcyc,
    output logic [63:0]          fetch_data,
    input  logic                 flush,
    output logic                 mem_reqcyc,
    input  logic                 mem_reqack,
    output logic [63:0]          mem_req,
    output logic [TAG_WIDTH-1:0] mem_reqtag,
    input  logic                 mem_respcyc,
    input  logic [0:LINE_BITS-1] mem_resp,
    input  logic [TAG_WIDTH-1:0] mem_resptag
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 58 - IDX_W;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] MISS_REQ  = 3'd2;
    localparam logic [2:0] WAIT_RESP = 3'd3;
    localparam logic [2:0] FLUSH     = 3'd4;

    logic [2:0]           state;
    logic [63:3]          req_addr;
    logic                 flush_pend;
    logic [NUM_SETS-1:0]  valid;
    logic [TAG_W-1:0]     tags [NUM_SETS];
    logic [0:LINE_BITS-1] data [NUM_SETS];

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [2:0]           word;
    logic [0:LINE_BITS-1] line;
    logic                 hit;
    logic                 fill;
    logic                 unused_ok;

    assign idx         = req_addr[6 +: IDX_W];
    assign tag         = req_addr[63 -: TAG_W];
    assign word        = req_addr[5:3];
    assign line        = data[idx];
    assign hit         = valid[idx] && tags[idx] == tag;
    assign fill        = state == WAIT_RESP && mem_respcyc;
    assign fetch_ready = reset && state == IDLE && !flush && !flush_pend;
    assign unused_ok   = ^{mem_resptag, fetch_addr[2:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            req_addr      <= '0;
            valid         <= '0;
            flush_pend    <= 1'b0;
            fetch_respcyc <= 1'b0;
            fetch_data    <= '0;
            mem_reqcyc    <= 1'b0;
            mem_req       <= '0;
            mem_reqtag    <= '0;
        end else begin
            fetch_respcyc <= 1'b0;
            // A flush seen mid-transaction is remembered and serviced once back in IDLE
            if (flush && state != IDLE && state != FLUSH)
                flush_pend <= 1'b1;
            case (state)
                IDLE:
                    if (flush || flush_pend) begin
                        flush_pend <= 1'b0;
                        state      <= FLUSH;
                    end else if (fetch_reqcyc) begin
                        req_addr <= fetch_addr[63:3];
                        state    <= LOOKUP;
                    end
                LOOKUP:
                    if (hit) begin
                        fetch_data    <= line[{word, 6'b0} +: 64];
                        fetch_respcyc <= 1'b1;
                        state         <= IDLE;
                    end else if (!mem_respcyc) begin
                        // Wait out any stale response so the fill only sees our own line
                        mem_reqcyc <= 1'b1;
                        mem_req    <= {req_addr[63:6], 6'b0};
                        mem_reqtag <= TAG_WIDTH'({MEM_TAG, 1'b1});
                        state      <= MISS_REQ;
                    end
                MISS_REQ:
                    if (mem_reqack) begin
                        mem_reqcyc <= 1'b0;
                        state      <= WAIT_RESP;
                    end
                WAIT_RESP:
                    if (mem_respcyc) begin
                        valid[idx] <= 1'b1;
                        state      <= LOOKUP;
                    end
                FLUSH: begin
                    valid <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tags[idx] <= tag;
            data[idx] <= mem_resp;
        end
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed and randomized check of icache_ctrl against a line-level cache model.
module tb_icache_ctrl;
    localparam int NS = 8;
    localparam int IW = $clog2(NS);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         fetch_reqcyc = 1'b0;
    logic [63:0]  fetch_addr = '0;
    logic         fetch_ready;
    logic         fetch_respcyc;
    logic [63:0]  fetch_data;
    logic         flush = 1'b0;
    logic         mem_reqcyc;
    logic         mem_reqack = 1'b0;
    logic [63:0]  mem_req;
    logic [12:0]  mem_reqtag;
    logic         mem_respcyc = 1'b0;
    logic [0:511] mem_resp = '0;
    logic [12:0]  mem_resptag = 13'h003;

    int           checks = 0;
    int           errors = 0;
    int           nreq = 0;
    bit           mval [NS];
    logic [63:0]  mline [NS];

    icache_ctrl #(.NUM_SETS(NS)) dut (
        .clk(clk), .reset(reset),
        .fetch_reqcyc(fetch_reqcyc), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_respcyc(fetch_respcyc), .fetch_data(fetch_data), .flush(flush),
        .mem_reqcyc(mem_reqcyc), .mem_reqack(mem_reqack), .mem_req(mem_req),
        .mem_reqtag(mem_reqtag), .mem_respcyc(mem_respcyc), .mem_resp(mem_resp),
        .mem_resptag(mem_resptag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reset && mem_reqcyc && mem_reqack) nreq <= nreq + 1;

    function automatic logic [63:0] mem_word(input logic [63:0] la, input int k);
        return la == 64'h1000 ? 64'h1111_0000_0000_0000 + 64'(k)
                              : (la * 64'h9E37_79B9_7F4A_7C15) ^ 64'(k);
    endfunction

    function automatic logic [0:511] line_of(input logic [63:0] a);
        logic [0:511] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = mem_word({a[63:6], 6'b0}, k);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (mval[j]) mval[j] = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a, input int ack_dly, input int resp_dly,
                         input int resp_len, input int flush_at, input int rst_at,
                         output logic [63:0] d, output int resp_k, output int fill_k,
                         output logic rdy);
        int seen, rwait, rleft, bad;
        bit acked;
        d = '0; resp_k = -1; fill_k = -1; rdy = 1'b0;
        seen = 0; rwait = -1; rleft = resp_len; bad = 0; acked = 1'b0;
        @(negedge clk);
        fetch_reqcyc = 1'b1;
        fetch_addr = a;
        for (int i = 0; i < 50 && !fetch_ready; i++) @(negedge clk);
        chk("ready_before_accept", 64'(fetch_ready), 1);
        @(negedge clk);
        fetch_reqcyc = 1'b0;
        chk("ready_low_in_lookup", 64'(fetch_ready), 0);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (rst_at > 0 && k == rst_at + 1) reset = 1'b1;
            if (rst_at > 0 && k > rst_at + 8) break;
            if (k == rst_at) begin
                reset = 1'b0;
                mem_reqack = 1'b0;
                acked = 1'b0;
                #1;
                chk("rst_ctrl_outputs", 64'({fetch_ready, fetch_respcyc, mem_reqcyc}), 0);
                chk("rst_fetch_data", fetch_data, 0);
                chk("rst_mem_req", mem_req, 0);
                chk("rst_mem_reqtag", 64'(mem_reqtag), 0);
            end
            if (fetch_respcyc) begin
                resp_k = k;
                d = fetch_data;
                rdy = fetch_ready;
                break;
            end
            flush = (k == flush_at);
            if (acked) begin
                mem_reqack = 1'b0;
                acked = 1'b0;
                rwait = resp_dly;
                if (mem_reqcyc) bad++;
            end else if (mem_reqcyc) begin
                if (mem_req !== {a[63:6], 6'b0} || mem_reqtag !== 13'h003) bad++;
                seen++;
                if (seen > ack_dly) begin
                    mem_reqack = 1'b1;
                    acked = 1'b1;
                end
            end
            if (rwait == 0 && rleft > 0) begin
                mem_respcyc = 1'b1;
                mem_resp = line_of(a);
                rleft--;
                if (fill_k < 0) fill_k = k + 1;
            end else begin
                mem_respcyc = 1'b0;
                if (rwait > 0) rwait--;
            end
        end
        mem_reqack = 1'b0;
        flush = 1'b0;
        while (mem_respcyc && rleft > 0) begin
            @(negedge clk);
            rleft--;
        end
        mem_respcyc = 1'b0;
        chk("mem_req_held_and_dropped", 64'(bad), 0);
    endtask

    task automatic run(input string name, input logic [63:0] a, input int ack_dly,
                       input int resp_dly, input int resp_len, input int flush_at);
        int i, n0, rk, fk;
        bit hit;
        logic [63:0] d, la;
        logic rdy;
        la = {a[63:6], 6'b0};
        i = int'(a[6 +: IW]);
        hit = mval[i] && mline[i] == la;
        n0 = nreq;
        fetch(a, ack_dly, resp_dly, resp_len, flush_at, 0, d, rk, fk, rdy);
        chk({name, "_answered"}, 64'(rk > 0), 1);
        chk({name, "_data"}, d, mem_word(la, int'(a[5:3])));
        chk({name, "_mem_reqs"}, 64'(nreq - n0), hit ? 1'b0 : 1'b1);
        chk({name, "_latency"}, 64'(hit ? rk : rk - fk), 1);
        if (hit && flush_at == 0) chk({name, "_ready_at_resp"}, 64'(rdy), 1);
        mval[i] = 1'b1;
        mline[i] = la;
        if (flush_at > 0) begin
            repeat (3) @(negedge clk);
            model_clear();
        end
    endtask

    initial begin
        logic [63:0] d, a;
        int rk, fk, n0;
        logic rdy;
        model_clear();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl_outputs", 64'({fetch_ready, fetch_respcyc, mem_reqcyc}), 0);
        chk("reset_fetch_data", fetch_data, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_mem_reqtag", 64'(mem_reqtag), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(fetch_ready), 1);

        run("first_miss", 64'h1000, 1, 2, 1, 0);
        run("hit_word3", 64'h1018, 0, 0, 1, 0);
        run("conf_a", 64'h1000, 0, 0, 1, 0);
        run("conf_b", 64'h1000 + 64 * NS, 0, 1, 1, 0);
        run("conf_a_again", 64'h1000, 0, 0, 1, 0);
        run("slow_ack", 64'h3040, 5, 1, 4, 0);
        run("slow_ack_hit", 64'h3048, 0, 0, 1, 0);
        run("flush_in_wait", 64'h5080, 0, 3, 1, 3);
        run("after_flush", 64'h1000, 0, 0, 1, 0);

        n0 = nreq;
        fetch(64'h2040, 0, 3, 2, 0, 3, d, rk, fk, rdy);
        model_clear();
        chk("rst_mid_miss_no_resp", 64'(rk), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_mid_miss_one_req", 64'(nreq - n0), 1);
        run("after_rst_a", 64'h1000, 0, 0, 1, 0);
        run("after_rst_b", 64'h2040, 1, 0, 2, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                model_clear();
            end
            a = 64'h10000 + 64'($urandom_range(0, 2)) * 64'h200
                + 64'($urandom_range(0, 3)) * 64 + 64'($urandom_range(0, 7)) * 8;
            run("rand", a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 3)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
